// File: rtl/exe_stage_if.sv
// Handshake/bus bundle between the ID/EXE register, the execute stage and the
// EXE/MEM register.
interface exe_stage_if;
    logic        in_valid;
    logic        exe_m2reg;
    logic        exe_wmem;
    logic [2:0]  exe_aluc;
    logic        exe_aluimm;
    logic        exe_shift;
    logic [31:0] exe_ra;
    logic [31:0] exe_rb;
    logic [31:0] exe_imm;
    logic        exe_wreg;
    logic [4:0]  exe_rn;
    logic        mem_stall;
    logic        exe_busy;
    logic        mem_valid;
    logic        mem_m2reg;
    logic        mem_wmem;
    logic        mem_wreg;
    logic [4:0]  mem_rn;
    logic [31:0] mem_alu;
    logic [31:0] mem_rb;

    modport master (
        output in_valid, exe_m2reg, exe_wmem, exe_aluc, exe_aluimm, exe_shift,
               exe_ra, exe_rb, exe_imm, exe_wreg, exe_rn, mem_stall,
        input  exe_busy, mem_valid, mem_m2reg, mem_wmem, mem_wreg, mem_rn,
               mem_alu, mem_rb
    );

    modport slave (
        input  in_valid, exe_m2reg, exe_wmem, exe_aluc, exe_aluimm, exe_shift,
               exe_ra, exe_rb, exe_imm, exe_wreg, exe_rn, mem_stall,
        output exe_busy, mem_valid, mem_m2reg, mem_wmem, mem_wreg, mem_rn,
               mem_alu, mem_rb
    );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: 32-bit ALU feeding the EXE/MEM register. Define EXE_MUL_EN to
// turn aluc=111 into an iterative 32-cycle multiply; otherwise it is signed SLT.
module exe_stage (
    input  logic        clk,
    input  logic        clrn,
    exe_stage_if.slave  bus
);
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic [31:0] alu_s;
    logic [31:0] wb_alu_s;
    logic        is_mul_s;
    logic        load_s;
    logic        valid_next_s;
    logic        busy_s;

    logic        mem_valid_r;
    logic        mem_m2reg_r;
    logic        mem_wmem_r;
    logic        mem_wreg_r;
    logic [4:0]  mem_rn_r;
    logic [31:0] mem_alu_r;
    logic [31:0] mem_rb_r;

`ifdef EXE_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;
    state_t      state_r;
    logic [5:0]  cnt_r;
    logic [31:0] mcand_r;
    logic [31:0] mplier_r;
    logic [31:0] acc_r;
`endif

    assign a_s = bus.exe_shift  ? {27'd0, bus.exe_imm[10:6]} : bus.exe_ra;
    assign b_s = bus.exe_aluimm ? bus.exe_imm : bus.exe_rb;

    // Single-cycle ALU result.
    always_comb begin
        alu_s = 32'd0;
        case (bus.exe_aluc)
            3'b000:  alu_s = a_s + b_s;
            3'b001:  alu_s = a_s - b_s;
            3'b010:  alu_s = a_s & b_s;
            3'b011:  alu_s = a_s | b_s;
            3'b100:  alu_s = a_s ^ b_s;
            3'b101:  alu_s = b_s << a_s[4:0];
            3'b110:  alu_s = b_s >> a_s[4:0];
`ifdef EXE_MUL_EN
            3'b111:  alu_s = 32'd0;
`else
            3'b111:  alu_s = ($signed(a_s) < $signed(b_s)) ? 32'd1 : 32'd0;
`endif
            default: alu_s = 32'd0;
        endcase
    end

    // Decide whether the EXE/MEM register loads this edge and from what.
    always_comb begin
        is_mul_s     = 1'b0;
        load_s       = 1'b0;
        valid_next_s = bus.in_valid;
        wb_alu_s     = alu_s;
        busy_s       = bus.mem_stall;
`ifdef EXE_MUL_EN
        is_mul_s = bus.in_valid & (bus.exe_aluc == 3'b111);
        case (state_r)
            IDLE: begin
                load_s = ~bus.mem_stall & ~is_mul_s;
                busy_s = bus.mem_stall | is_mul_s;
            end
            MUL: begin
                busy_s = 1'b1;
            end
            DONE: begin
                load_s       = ~bus.mem_stall;
                valid_next_s = 1'b1;
                wb_alu_s     = acc_r;
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
`else
        load_s = ~bus.mem_stall;
`endif
    end

    // Multiplier FSM and EXE/MEM pipeline register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mem_valid_r <= 1'b0;
            mem_m2reg_r <= 1'b0;
            mem_wmem_r  <= 1'b0;
            mem_wreg_r  <= 1'b0;
            mem_rn_r    <= 5'd0;
            mem_alu_r   <= 32'd0;
            mem_rb_r    <= 32'd0;
`ifdef EXE_MUL_EN
            state_r     <= IDLE;
            cnt_r       <= 6'd0;
            mcand_r     <= 32'd0;
            mplier_r    <= 32'd0;
            acc_r       <= 32'd0;
`endif
        end else begin
            if (load_s) begin
                mem_valid_r <= valid_next_s;
                mem_m2reg_r <= bus.exe_m2reg;
                mem_wmem_r  <= bus.exe_wmem;
                mem_wreg_r  <= bus.exe_wreg;
                mem_rn_r    <= bus.exe_rn;
                mem_alu_r   <= wb_alu_s;
                mem_rb_r    <= bus.exe_rb;
            end
`ifdef EXE_MUL_EN
            case (state_r)
                IDLE: begin
                    if (is_mul_s) begin
                        mcand_r  <= a_s;
                        mplier_r <= b_s;
                        acc_r    <= 32'd0;
                        cnt_r    <= 6'd0;
                        state_r  <= MUL;
                        if (!bus.mem_stall) begin
                            mem_valid_r <= 1'b0;
                        end
                    end
                end
                MUL: begin
                    // Shift-add step; only the low 32 product bits survive.
                    if (mplier_r[0]) begin
                        acc_r <= acc_r + mcand_r;
                    end
                    mcand_r  <= {mcand_r[30:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[31:1]};
                    cnt_r    <= cnt_r + 6'd1;
                    if (cnt_r == 6'd31) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.mem_stall) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
`endif
        end
    end

    assign bus.exe_busy  = busy_s;
    assign bus.mem_valid = mem_valid_r;
    assign bus.mem_m2reg = mem_m2reg_r;
    assign bus.mem_wmem  = mem_wmem_r;
    assign bus.mem_wreg  = mem_wreg_r;
    assign bus.mem_rn    = mem_rn_r;
    assign bus.mem_alu   = mem_alu_r;
    assign bus.mem_rb    = mem_rb_r;
endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage; covers the multiplier build when EXE_MUL_EN
// is defined and the signed-SLT build otherwise.
module tb_exe_stage;
    logic clk;
    logic clrn;
    exe_stage_if bus ();

    exe_stage dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rb;
        logic [4:0]  rn;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
    } exp_t;

    exp_t exp_q[$];
    int   checks_s = 0;
    int   errors_s = 0;
    logic stall_q  = 1'b0;
    logic clrn_q   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_s++;
        if (act !== exp) begin
            errors_s++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (op)
            3'b000: return a + b;
            3'b001: return a - b;
            3'b010: return a & b;
            3'b011: return a | b;
            3'b100: return a ^ b;
            3'b101: return b << a[4:0];
            3'b110: return b >> a[4:0];
            default: begin
`ifdef EXE_MUL_EN
                p = {32'd0, a} * {32'd0, b};
                return p[31:0];
`else
                p = 64'd0;
                return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`endif
            end
        endcase
    endfunction

    always @(posedge clk) begin
        stall_q <= bus.mem_stall;
        clrn_q  <= clrn;
    end

    // Fresh EXE/MEM contents appear only after an unstalled edge with mem_valid set.
    always @(negedge clk) begin
        if (clrn && clrn_q && !stall_q && bus.mem_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mem_alu", bus.mem_alu, e.alu);
                chk("mem_rb", bus.mem_rb, e.rb);
                chk("mem_rn", {27'd0, bus.mem_rn}, {27'd0, e.rn});
                chk("mem_ctl", {29'd0, bus.mem_wreg, bus.mem_m2reg, bus.mem_wmem},
                    {29'd0, e.wreg, e.m2reg, e.wmem});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] ra, input logic [31:0] rb,
                         input logic [31:0] imm, input logic aluimm, input logic shift,
                         input logic wreg, input logic m2reg, input logic wmem, input logic [4:0] rn,
                         input logic [31:0] exp_alu);
        exp_t e;
        bus.in_valid   = 1'b1;
        bus.exe_aluc   = op;
        bus.exe_ra     = ra;
        bus.exe_rb     = rb;
        bus.exe_imm    = imm;
        bus.exe_aluimm = aluimm;
        bus.exe_shift  = shift;
        bus.exe_wreg   = wreg;
        bus.exe_m2reg  = m2reg;
        bus.exe_wmem   = wmem;
        bus.exe_rn     = rn;
        e.alu = exp_alu; e.rb = rb; e.rn = rn; e.wreg = wreg; e.m2reg = m2reg; e.wmem = wmem;
        exp_q.push_back(e);
    endtask

    // Present an instruction, hold it while busy, release after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] ra, input logic [31:0] rb,
                         input logic [31:0] imm, input logic aluimm, input logic shift,
                         input logic wreg, input logic m2reg, input logic wmem, input logic [4:0] rn,
                         input logic [31:0] exp_alu, output int busy_cycles);
        int n;
        drive(op, ra, rb, imm, aluimm, shift, wreg, m2reg, wmem, rn, exp_alu);
        n = 0;
        while (bus.exe_busy && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk("busy_timeout", 32'd1, 32'd0);
        step();
        bus.in_valid = 1'b0;
        busy_cycles = n;
    endtask

    initial begin
        int bc;
        logic [31:0] ra, rb, imm, a, b;
        logic [2:0]  op;
        logic        ai, sh;

        clrn = 1'b0;
        bus.in_valid = 1'b0; bus.exe_aluc = 3'd0; bus.exe_ra = 32'd0; bus.exe_rb = 32'd0;
        bus.exe_imm = 32'd0; bus.exe_aluimm = 1'b0; bus.exe_shift = 1'b0; bus.exe_wreg = 1'b0;
        bus.exe_m2reg = 1'b0; bus.exe_wmem = 1'b0; bus.exe_rn = 5'd0; bus.mem_stall = 1'b0;
        step(); step();
        chk("rst_valid", {31'd0, bus.mem_valid}, 32'd0);
        chk("rst_alu", bus.mem_alu, 32'd0);
        chk("rst_busy", {31'd0, bus.exe_busy}, 32'd0);
        clrn = 1'b1;
        step();

        issue(3'b000, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'd12, bc);
        chk("add_valid", {31'd0, bus.mem_valid}, 32'd1);
        issue(3'b001, 32'd2, 32'hDEADBEEF, 32'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, bc);
        issue(3'b101, 32'd0, 32'd1, 32'h00000100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'd16, bc);
        issue(3'b110, 32'd0, 32'h80000000, 32'h00000100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd31, 32'h08000000, bc);

        // Stall holds an ADD result.
        issue(3'b000, 32'd100, 32'd23, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 32'd123, bc);
        bus.mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_busy", {31'd0, bus.exe_busy}, 32'd1);
            step();
            chk("stall_alu", bus.mem_alu, 32'd123);
            chk("stall_valid", {31'd0, bus.mem_valid}, 32'd1);
        end
        bus.mem_stall = 1'b0;
        step();
        chk("bubble_valid", {31'd0, bus.mem_valid}, 32'd0);

`ifdef EXE_MUL_EN
        issue(3'b111, 32'd6, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd8, 32'd42, bc);
        chk("mul_busy_cycles", bc, 32'd33);
        chk("mul_valid", {31'd0, bus.mem_valid}, 32'd1);
        issue(3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 32'd1, bc);

        // MUL parked in DONE by a stall.
        drive(3'b111, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd10, 32'd3000);
        for (int i = 0; i < 33; i++) step();
        bus.mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("done_busy", {31'd0, bus.exe_busy}, 32'd1);
            step();
            chk("done_hold_valid", {31'd0, bus.mem_valid}, 32'd0);
        end
        bus.mem_stall = 1'b0;
        chk("done_free", {31'd0, bus.exe_busy}, 32'd0);
        step();
        bus.in_valid = 1'b0;
        chk("done_out", bus.mem_alu, 32'd3000);

        // Reset in the middle of a multiply.
        drive(3'b111, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd11, 32'd81);
        for (int i = 0; i < 11; i++) step();
        bus.in_valid = 1'b0;
        clrn = 1'b0;
        #1;
        exp_q.delete();
        chk("mrst_alu", bus.mem_alu, 32'd0);
        chk("mrst_ctl", {25'd0, bus.mem_valid, bus.mem_wreg, bus.mem_rn}, 32'd0);
        chk("mrst_busy", {31'd0, bus.exe_busy}, 32'd0);
        step();
        clrn = 1'b1;
        step();
        issue(3'b000, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 32'd2, bc);
        chk("post_rst_busy", bc, 32'd0);
`else
        issue(3'b111, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 32'd1, bc);
        chk("slt_busy", bc, 32'd0);
        issue(3'b111, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6, 32'd0, bc);
`endif

        for (int i = 0; i < 24; i++) begin
            op  = 3'($urandom_range(0, 7));
            ra  = $urandom; rb = $urandom; imm = $urandom;
            ai  = 1'($urandom_range(0, 1));
            sh  = 1'($urandom_range(0, 1));
            a   = sh ? {27'd0, imm[10:6]} : ra;
            b   = ai ? imm : rb;
            issue(op, ra, rb, imm, ai, sh, 1'b1, 1'($urandom_range(0, 1)), 1'b0,
                  5'($urandom_range(0, 31)), ref_alu(op, a, b), bc);
        end
        step(); step();
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_s, errors_s);
        $finish;
    end
endmodule
